// File: rtl/accel_pkg.sv
// Shared types and sizing for the accelerator's compute core and its requesters.
package accel_pkg;

  localparam int NUM_PROCESSING_UNITS = 4;
  localparam int UNIT_ID_W            = $clog2(NUM_PROCESSING_UNITS);
  localparam int VEC_LEN              = 4;
  localparam int DATA_W               = 16;
  localparam int FRAC_W               = 8;

  typedef logic [VEC_LEN-1:0][DATA_W-1:0]              vector_data_t;
  typedef logic [VEC_LEN-1:0][VEC_LEN-1:0][DATA_W-1:0] matrix_data_t;

  typedef enum logic [1:0] {
    COMP_ADD    = 2'b00,
    COMP_MUL    = 2'b01,
    COMP_MATVEC = 2'b10,
    COMP_PASS   = 2'b11
  } computation_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } core_state_t;

  typedef struct packed {
    logic [UNIT_ID_W-1:0] unit_id;
    computation_type_t    comp_type;
  } control_packet_t;

endpackage

// File: rtl/scu_narrow.sv
// Arithmetic right shift followed by narrowing to OUT_W bits.
// SCU_SATURATE_EN selects saturation; otherwise the low bits are kept (wrap).
module scu_narrow #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  i_value,
  output logic        [OUT_W-1:0] o_value
);

  logic signed [IN_W-1:0] w_shifted;

  assign w_shifted = i_value >>> SHIFT;

`ifdef SCU_SATURATE_EN
  // Fits only when every bit above the output sign bit matches the sign.
  logic [IN_W-OUT_W:0] w_top;
  logic                w_pos_ovf;
  logic                w_neg_ovf;

  assign w_top     = w_shifted[IN_W-1:OUT_W-1];
  assign w_pos_ovf = !w_shifted[IN_W-1] && (|w_top);
  assign w_neg_ovf =  w_shifted[IN_W-1] && !(&w_top);

  always_comb begin
    o_value = OUT_W'(w_shifted);
    if (w_pos_ovf) begin
      o_value = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_neg_ovf) begin
      o_value = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
`else
  assign o_value = OUT_W'(w_shifted);
`endif

endmodule

// File: rtl/shared_compute_core.sv
// Shared Q8.8 vector engine: ADD, MUL, PASS in one CALC cycle, MATVEC one row per cycle.
// Narrowing behaviour is selected by SCU_SATURATE_EN (see scu_narrow).
module shared_compute_core #(
  parameter int VEC_LEN = accel_pkg::VEC_LEN,
  parameter int DATA_W  = accel_pkg::DATA_W,
  parameter int FRAC_W  = accel_pkg::FRAC_W
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [1:0]                                unit_id,
  input  logic                                      request,
  output logic                                      ready,
  output logic                                      done,
  input  logic [1:0]                                comp_type,
  input  logic [VEC_LEN-1:0][DATA_W-1:0]            vector_a,
  input  logic [VEC_LEN-1:0][DATA_W-1:0]            vector_b,
  input  logic [VEC_LEN-1:0][VEC_LEN-1:0][DATA_W-1:0] matrix_in,
  output logic [VEC_LEN-1:0][DATA_W-1:0]            result,
  output logic [1:0]                                owner_id
);

  import accel_pkg::*;

  localparam int ROW_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int SUM_W  = DATA_W + 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + ROW_W;

  core_state_t                                 r_state;
  core_state_t                                 w_state_next;
  control_packet_t                             r_ctrl;
  logic [VEC_LEN-1:0][DATA_W-1:0]              r_vec_a;
  logic [VEC_LEN-1:0][DATA_W-1:0]              r_vec_b;
  logic [VEC_LEN-1:0][VEC_LEN-1:0][DATA_W-1:0] r_matrix;
  logic [VEC_LEN-1:0][DATA_W-1:0]              r_mv_buf;
  logic [VEC_LEN-1:0][DATA_W-1:0]              r_result;
  logic [ROW_W-1:0]                            r_row;

  logic                           w_accept;
  logic                           w_calc_end;
  logic                           w_last_row;
  logic [VEC_LEN-1:0][DATA_W-1:0] w_add_res;
  logic [VEC_LEN-1:0][DATA_W-1:0] w_mul_res;
  logic [VEC_LEN-1:0][PROD_W-1:0] w_mv_prod;
  logic [ACC_W-1:0]               w_row_acc;
  logic [DATA_W-1:0]              w_row_res;
  logic [VEC_LEN-1:0][DATA_W-1:0] w_result_next;

  assign w_last_row = (r_ctrl.comp_type != COMP_MATVEC) ||
                      (r_row == ROW_W'(VEC_LEN - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_calc_end   = 1'b0;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (request) begin
          w_accept     = 1'b1;
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last_row) begin
          w_calc_end   = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Element-wise lanes plus one MAC column per lane for the current MATVEC row.
  for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_lane
    logic [SUM_W-1:0]  w_sum;
    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_m_ext;

    assign w_sum   = {r_vec_a[gi][DATA_W-1], r_vec_a[gi]} +
                     {r_vec_b[gi][DATA_W-1], r_vec_b[gi]};
    assign w_a_ext = {{DATA_W{r_vec_a[gi][DATA_W-1]}}, r_vec_a[gi]};
    assign w_b_ext = {{DATA_W{r_vec_b[gi][DATA_W-1]}}, r_vec_b[gi]};
    assign w_m_ext = {{DATA_W{r_matrix[r_row][gi][DATA_W-1]}}, r_matrix[r_row][gi]};
    assign w_mv_prod[gi] = w_m_ext * w_a_ext;

    scu_narrow #(.IN_W(SUM_W), .OUT_W(DATA_W), .SHIFT(0)) u_add_narrow (
      .i_value (w_sum),
      .o_value (w_add_res[gi])
    );

    scu_narrow #(.IN_W(PROD_W), .OUT_W(DATA_W), .SHIFT(FRAC_W)) u_mul_narrow (
      .i_value (w_a_ext * w_b_ext),
      .o_value (w_mul_res[gi])
    );
  end

  always_comb begin
    w_row_acc = '0;
    for (int c = 0; c < VEC_LEN; c++) begin
      w_row_acc = w_row_acc + {{(ACC_W-PROD_W){w_mv_prod[c][PROD_W-1]}}, w_mv_prod[c]};
    end
  end

  scu_narrow #(.IN_W(ACC_W), .OUT_W(DATA_W), .SHIFT(FRAC_W)) u_row_narrow (
    .i_value (w_row_acc),
    .o_value (w_row_res)
  );

  // The last MATVEC row is still combinational when the result is committed.
  always_comb begin
    w_result_next = r_vec_a;
    case (r_ctrl.comp_type)
      COMP_ADD:    w_result_next = w_add_res;
      COMP_MUL:    w_result_next = w_mul_res;
      COMP_MATVEC: begin
        w_result_next              = r_mv_buf;
        w_result_next[VEC_LEN-1]   = w_row_res;
      end
      default:     w_result_next = r_vec_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ctrl   <= '0;
      r_vec_a  <= '0;
      r_vec_b  <= '0;
      r_matrix <= '0;
      r_mv_buf <= '0;
      r_result <= '0;
      r_row    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_ctrl.unit_id   <= unit_id;
        r_ctrl.comp_type <= computation_type_t'(comp_type);
        r_vec_a          <= vector_a;
        r_vec_b          <= vector_b;
        r_matrix         <= matrix_in;
        r_row            <= '0;
      end
      if ((r_state == ST_CALC) && (r_ctrl.comp_type == COMP_MATVEC)) begin
        r_mv_buf[r_row] <= w_row_res;
        r_row           <= r_row + ROW_W'(1);
      end
      if (w_calc_end) begin
        r_result <= w_result_next;
      end
    end
  end

  assign result   = r_result;
  assign owner_id = r_ctrl.unit_id;

endmodule

// File: tb/tb_shared_compute_core.sv
// Directed and randomized checks of shared_compute_core against a plain-arithmetic model.
module tb_shared_compute_core;

  localparam int VL = 4;
  localparam int DW = 16;
  localparam int FW = 8;

  typedef logic [VL-1:0][DW-1:0]        vec_t;
  typedef logic [VL-1:0][VL-1:0][DW-1:0] mat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] unit_id;
  logic       request;
  logic       ready;
  logic       done;
  logic [1:0] comp_type;
  vec_t       vector_a;
  vec_t       vector_b;
  mat_t       matrix_in;
  vec_t       result;
  logic [1:0] owner_id;

  int vectors     = 0;
  int miscompares = 0;

  shared_compute_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .unit_id   (unit_id),
    .request   (request),
    .ready     (ready),
    .done      (done),
    .comp_type (comp_type),
    .vector_a  (vector_a),
    .vector_b  (vector_b),
    .matrix_in (matrix_in),
    .result    (result),
    .owner_id  (owner_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference narrowing: arithmetic shift of the exact value, then clamp or wrap.
  function automatic logic [DW-1:0] narrow(input longint v, input int sh);
    longint t;
    t = v >>> sh;
`ifdef SCU_SATURATE_EN
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
`endif
    return t[DW-1:0];
  endfunction

  function automatic vec_t model(input logic [1:0] op, input vec_t a, input vec_t b, input mat_t m);
    vec_t   r;
    longint s;
    for (int i = 0; i < VL; i++) begin
      case (op)
        2'b00: r[i] = narrow(longint'($signed(a[i])) + longint'($signed(b[i])), 0);
        2'b01: r[i] = narrow(longint'($signed(a[i])) * longint'($signed(b[i])), FW);
        2'b10: begin
          s = 0;
          for (int c = 0; c < VL; c++) s += longint'($signed(m[i][c])) * longint'($signed(a[c]));
          r[i] = narrow(s, FW);
        end
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VL; i++) begin
      if ($urandom_range(0, 2) == 0) v[i] = DW'($urandom);
      else v[i] = DW'(int'($urandom_range(0, 2047)) - 1024);
    end
    return v;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < VL; r++) m[r] = rand_vec();
    return m;
  endfunction

  task automatic scramble_inputs();
    vector_a  = rand_vec();
    vector_b  = rand_vec();
    matrix_in = rand_mat();
    unit_id   = 2'($urandom);
    comp_type = 2'($urandom);
  endtask

  // One full transaction: accept, latency, busy window, result, done width.
  task automatic run_op(input string name, input logic [1:0] op, input vec_t a, input vec_t b,
                        input mat_t m, input logic [1:0] id);
    vec_t exp;
    int   lat;
    int   ready_high;
    bit   got;
    exp = model(op, a, b, m);
    @(negedge clk);
    chk({name, "_ready_idle"}, 64'(ready), 64'd1);
    unit_id = id; comp_type = op; vector_a = a; vector_b = b; matrix_in = m; request = 1'b1;
    @(posedge clk); #1;
    request = 1'b0;
    scramble_inputs();
    lat = 0; got = 1'b0; ready_high = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ready) ready_high++;
      if (done) got = 1'b1;
    end
    chk({name, "_latency"}, 64'(lat), (op == 2'b10) ? 64'(VL + 1) : 64'd2);
    chk({name, "_ready_low"}, 64'(ready_high), 64'd0);
    chk({name, "_result"}, 64'(result), 64'(exp));
    chk({name, "_owner"}, 64'(owner_id), 64'(id));
    @(negedge clk);
    chk({name, "_done_width"}, 64'(done), 64'd0);
    chk({name, "_ready_back"}, 64'(ready), 64'd1);
    chk({name, "_result_hold"}, 64'(result), 64'(exp));
    $display("txn %-8s op=%0d id=%0d lat=%0d result=%h", name, op, id, lat, result);
  endtask

  initial begin
    vec_t a, b, zero_v;
    mat_t m, ident;
    int   lat;
    int   done_seen;
    bit   got;

    zero_v = '0;
    rst_n = 1'b1; request = 1'b0; unit_id = 2'd0; comp_type = 2'd0;
    vector_a = '0; vector_b = '0; matrix_in = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_owner", 64'(owner_id), 64'd0);
    rst_n = 1'b1;

    // ADD from the test plan; lane 3 overflows.
    a[0] = 16'h0100; a[1] = 16'h0200; a[2] = 16'hFF00; a[3] = 16'h7F00;
    b[0] = 16'h0100; b[1] = 16'h0100; b[2] = 16'h0100; b[3] = 16'h0200;
    run_op("add_tp", 2'b00, a, b, '0, 2'd1);
    chk("add_tp_lane0", 64'(result[0]), 64'h0200);
    chk("add_tp_lane2", 64'(result[2]), 64'h0000);
`ifdef SCU_SATURATE_EN
    chk("add_tp_lane3", 64'(result[3]), 64'h7FFF);
`else
    chk("add_tp_lane3", 64'(result[3]), 64'h8100);
`endif

    // MUL from the test plan.
    a[0] = 16'h0200; a[1] = 16'hFE00; a[2] = 16'h0080; a[3] = 16'h0001;
    b[0] = 16'h0180; b[1] = 16'h0100; b[2] = 16'h0080; b[3] = 16'h0001;
    run_op("mul_tp", 2'b01, a, b, '0, 2'd2);
    chk("mul_tp_vec", 64'(result), {16'h0000, 16'h0040, 16'hFE00, 16'h0300});

    // MATVEC with identity returns a.
    for (int r = 0; r < VL; r++)
      for (int c = 0; c < VL; c++) ident[r][c] = (r == c) ? 16'h0100 : 16'h0000;
    a[0] = 16'h0100; a[1] = 16'h0200; a[2] = 16'h0300; a[3] = 16'h0400;
    run_op("mv_ident", 2'b10, a, zero_v, ident, 2'd3);
    chk("mv_ident_eq_a", 64'(result), 64'(a));

    for (int n = 0; n < 40; n++) begin
      run_op("random", 2'($urandom), rand_vec(), rand_vec(), rand_mat(), 2'($urandom));
    end

    // A PASS request held high during MATVEC is ignored until IDLE, then taken.
    a = rand_vec(); m = rand_mat();
    @(negedge clk);
    unit_id = 2'd0; comp_type = 2'b10; vector_a = a; vector_b = zero_v; matrix_in = m; request = 1'b1;
    @(posedge clk); #1;
    comp_type = 2'b11; unit_id = 2'd2; matrix_in = rand_mat();
    for (int i = 0; i < VL; i++) vector_a[i] = DW'(i + 1);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (done) got = 1'b1;
    end
    chk("busy_mv_latency", 64'(lat), 64'(VL + 1));
    chk("busy_mv_result", 64'(result), 64'(model(2'b10, a, zero_v, m)));
    chk("busy_mv_owner", 64'(owner_id), 64'd0);
    $display("txn busy_mv  lat=%0d result=%h", lat, result);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (lat == 1) chk("busy_idle_ready", 64'(ready), 64'd1);
      if (done) got = 1'b1;
    end
    request = 1'b0;
    chk("busy_pass_latency", 64'(lat), 64'd3);
    chk("busy_pass_result", 64'(result), {16'd4, 16'd3, 16'd2, 16'd1});
    chk("busy_pass_owner", 64'(owner_id), 64'd2);
    @(negedge clk);
    chk("busy_pass_done_width", 64'(done), 64'd0);
    $display("txn busy_pass lat=%0d result=%h", lat, result);

    // Reset during the second MATVEC CALC cycle aborts with no completion.
    @(negedge clk);
    comp_type = 2'b10; unit_id = 2'd3; vector_a = rand_vec(); matrix_in = rand_mat(); request = 1'b1;
    @(posedge clk); #1;
    request = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_owner", 64'(owner_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_result_after", 64'(result), 64'd0);
    $display("txn abort    done_seen=%0d result=%h", done_seen, result);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
